// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI master frame controller.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    TURN = 3'd2,
    RECV = 3'd3,
    END  = 3'd4
  } master_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_WAIT = 1;
  localparam int DEF_FRAME_W = DEF_DATA_W + 3;

endpackage

// File: rtl/spi_piso_sipo.sv
// Frame shift-out register (bits below the MSB), miso shift-in register and
// the shared bit counter used by both SEND and RECV.
module spi_piso_sipo
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FRAME_W = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-2:0] tx_bits,
  input  logic               rx_load,
  input  logic               shift_out,
  input  logic               shift_in,
  input  logic               miso,
  output logic               tx_next,
  output logic               cnt_zero,
  output logic [DATA_W-1:0]  rx_next
);

  localparam int CNT_W = $clog2(FRAME_W);

  logic [FRAME_W-2:0] tx_shift;
  logic [DATA_W-2:0]  rx_shift;
  logic [CNT_W-1:0]   bit_cnt;

  // The frame MSB goes out straight from the top, so only the rest is held here.
  assign tx_next  = tx_shift[FRAME_W-2];
  assign rx_next  = {rx_shift, miso};
  assign cnt_zero = (bit_cnt == CNT_W'(0));

  // Shift registers and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load) begin
        tx_shift <= tx_bits;
      end else if (shift_out) begin
        tx_shift <= {tx_shift[FRAME_W-3:0], 1'b0};
      end else begin
        tx_shift <= tx_shift;
      end

      if (shift_in) begin
        rx_shift <= rx_next[DATA_W-2:0];
      end else begin
        rx_shift <= rx_shift;
      end

      if (load) begin
        bit_cnt <= CNT_W'(FRAME_W - 1);
      end else if (rx_load) begin
        bit_cnt <= CNT_W'(DATA_W - 1);
      end else if ((shift_out || shift_in) && !cnt_zero) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
      end else begin
        bit_cnt <= bit_cnt;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master frame controller: sends {start, cmd, data} MSB-first on mosi and,
// for RD_DATA, captures a byte from miso after a turnaround.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = DEF_RD_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              miso,
  output logic              ss_n,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int FRAME_W = DATA_W + 3;
  localparam int WAIT_W  = (RD_WAIT > 1) ? $clog2(RD_WAIT + 1) : 1;

  master_state_t     state, next_state;
  spi_cmd_t          cur_cmd;
  logic [WAIT_W-1:0] wait_cnt;
  logic [FRAME_W-1:0] frame_in;
  logic              load, rx_load, shift_out, shift_in;
  logic              tx_next, cnt_zero, mosi_next, capture;
  logic [DATA_W-1:0] rx_next;

  assign frame_in = {cmd[1], cmd, wr_data};

  spi_piso_sipo #(
    .DATA_W (DATA_W),
    .FRAME_W(FRAME_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .tx_bits  (frame_in[FRAME_W-2:0]),
    .rx_load  (rx_load),
    .shift_out(shift_out),
    .shift_in (shift_in),
    .miso     (miso),
    .tx_next  (tx_next),
    .cnt_zero (cnt_zero),
    .rx_next  (rx_next)
  );

  // State, latched command and turnaround counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_cmd  <= WR_ADDR;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        cur_cmd <= spi_cmd_t'(cmd);
      end else begin
        cur_cmd <= cur_cmd;
      end
      if ((state == SEND) && (next_state == TURN)) begin
        wait_cnt <= WAIT_W'(RD_WAIT - 1);
      end else if ((state == TURN) && (wait_cnt != WAIT_W'(0))) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end else begin
        wait_cnt <= wait_cnt;
      end
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = start ? SEND : IDLE;
      SEND: begin
        if (cnt_zero) begin
          if (cur_cmd == RD_DATA) begin
            next_state = (RD_WAIT > 0) ? TURN : RECV;
          end else begin
            next_state = END;
          end
        end else begin
          next_state = SEND;
        end
      end
      TURN:    next_state = (wait_cnt == WAIT_W'(0)) ? RECV : TURN;
      RECV:    next_state = cnt_zero ? END : RECV;
      END:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    load      = (state == IDLE) && start;
    shift_out = (state == SEND);
    shift_in  = (state == RECV);
    rx_load   = (next_state == RECV) && (state != RECV);
    capture   = (state == RECV) && (next_state == END);

    // Outputs are registered, so mosi is computed one cycle ahead of the wire.
    if (load) begin
      mosi_next = frame_in[FRAME_W-1];
    end else if ((state == SEND) && !cnt_zero) begin
      mosi_next = tx_next;
    end else begin
      mosi_next = 1'b0;
    end
  end

  // Registered outputs, driven from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      ss_n     <= (next_state == IDLE) || (next_state == END);
      mosi     <= mosi_next;
      busy     <= (next_state != IDLE);
      done     <= (next_state == END);
      rd_valid <= capture;
      if (capture) begin
        rd_data <= rx_next;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed table, hand sequences for
// busy/back-to-back/reset corners, and random frames against a frame-level model.
module tb_spi_master_ctrl;

  localparam int DW = 8;
  localparam int RW = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       miso = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       ss_n, mosi, busy, done, rd_valid;
  logic [7:0] rd_data;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_rd = 8'h00;

  typedef struct {
    logic [1:0]  c;
    logic [7:0]  d;
    logic [7:0]  mb;
    logic [10:0] bits;
    int          lat;
    logic [7:0]  rd_after;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(DW), .RD_WAIT(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmd     (cmd),
    .wr_data (wr_data),
    .miso    (miso),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame model: bit stream and start-to-done latency from the framing rules.
  function automatic logic [10:0] model_frame(input logic [1:0] c, input logic [7:0] d);
    return {c[1], c, d};
  endfunction

  function automatic int model_latency(input logic [1:0] c);
    return (c == 2'b11) ? (DW + 4 + RW + DW) : (DW + 4);
  endfunction

  // Called #1 into an IDLE cycle; checks every cycle through the IDLE after END.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] mb,
                           input logic [10:0] bits, input int lat, input int glitch_k);
    bit         rd;
    int         recv0;
    logic       mosi_e;
    logic [7:0] rdd;
    logic [12:0] act, exp;
    rd    = (c == 2'b11);
    recv0 = DW + 3 + RW + 1;
    cmd = c; wr_data = d; start = 1'b1;
    check("ss_n_before_accept", 32'(ss_n), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; cmd = 2'($urandom_range(0, 3)); wr_data = 8'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      if (rd && k >= recv0 && k < recv0 + DW) miso = mb[DW - 1 - (k - recv0)];
      else miso = 1'($urandom);
      if (k == glitch_k) begin
        start = 1'b1; cmd = ~c;
      end else begin
        start = 1'b0;
      end
      mosi_e = (k <= DW + 3) ? bits[DW + 3 - k] : 1'b0;
      rdd    = (rd && k >= lat) ? mb : last_rd;
      exp = {1'(k >= lat), mosi_e, 1'(k <= lat), 1'(k == lat), 1'(rd && k == lat), rdd};
      act = {ss_n, mosi, busy, done, rd_valid, rd_data};
      check($sformatf("frame cmd=%0d data=%h k=%0d {ss_n,mosi,busy,done,rd_valid,rd_data}",
                      c, d, k), 32'(act), 32'(exp));
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (rd) last_rd = mb;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle {ss_n,mosi,busy,done,rd_valid}",
            32'({ss_n, mosi, busy, done, rd_valid}), 32'(5'b10000));
      check("idle rd_data hold", 32'(rd_data), 32'(last_rd));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rc;
    logic [7:0] rdat, rmb;
    int         p;

    tbl[0] = '{2'b00, 8'hA5, 8'h00, 11'b000_1010_0101, 12, 8'h00};
    tbl[1] = '{2'b01, 8'h3C, 8'h00, 11'b001_0011_1100, 12, 8'h00};
    tbl[2] = '{2'b11, 8'h00, 8'hC3, 11'b111_0000_0000, 21, 8'hC3};
    tbl[3] = '{2'b10, 8'h5A, 8'h00, 11'b110_0101_1010, 12, 8'hC3};
    tbl[4] = '{2'b11, 8'hFF, 8'h81, 11'b111_1111_1111, 21, 8'h81};

    // Reset held for 3 cycles, then 10 quiet idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset {ss_n,mosi,busy,done,rd_valid}",
          32'({ss_n, mosi, busy, done, rd_valid}), 32'(5'b10000));
    check("reset rd_data", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(10);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].c, tbl[i].d, tbl[i].mb, tbl[i].bits, tbl[i].lat, 0);
      check($sformatf("table %0d rd_data after frame", i), 32'(rd_data), 32'(tbl[i].rd_after));
      idle_cycles(1);
    end

    // Start pulse during SEND is ignored and not queued.
    run_frame(2'b01, 8'h3C, 8'h00, 11'b001_0011_1100, 12, 5);
    idle_cycles(3);

    // Start held high: two frames with exactly two ss_n-high cycles between.
    cmd = 2'b01; wr_data = 8'h96; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 28; k++) begin
      if (k == 14) start = 1'b0;
      p = (k <= 13) ? k - 1 : k - 14;
      check($sformatf("b2b k=%0d {ss_n,done}", k), 32'({ss_n, done}),
            32'({1'(!(k <= 26 && p < 11)), 1'(k <= 26 && p == 11)}));
      @(posedge clk); #1;
    end

    // Reset in the middle of SEND: ss_n rises at once, rd_data clears.
    cmd = 2'b01; wr_data = 8'hF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid-frame ss_n low before reset", 32'(ss_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset {ss_n,mosi,busy,done,rd_valid}",
          32'({ss_n, mosi, busy, done, rd_valid}), 32'(5'b10000));
    check("async reset rd_data", 32'(rd_data), 32'h0);
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(5);
    run_frame(2'b00, 8'h69, 8'h00, model_frame(2'b00, 8'h69), model_latency(2'b00), 0);

    // Random frames against the model.
    for (int i = 0; i < 24; i++) begin
      rc   = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      rmb  = 8'($urandom);
      run_frame(rc, rdat, rmb, model_frame(rc, rdat), model_latency(rc), 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
